// File: rtl/dtree_frame_loader.sv
// Purpose : assembles N_FEAT byte features into a stable parallel bus for a slow
//           printed decision tree, waits SETTLE_CYCLES, then captures the class.
// Latency : N_FEAT accept edges + SETTLE_CYCLES from first beat to out_valid.
// Backpr. : in_ready low in SETTLE/OUT; out_valid holds until out_ready.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      feature byte stream handshake; in_data = feature Xk on beat k
//   in_last                final beat of a frame
//   feat_bus               committed features, X0 in the low byte
//   tree_class             combinational tree output computed from feat_bus
//   out_valid/out_ready    class result handshake; out_class = captured class
//   frame_err, err_count   malformed-frame pulse and saturating counter
//   busy                   high while settling or presenting a result
module dtree_frame_loader #(
  parameter int N_FEAT        = 9,
  parameter int FEAT_W        = 8,
  parameter int CLASS_W       = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [FEAT_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [N_FEAT*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]       tree_class,
  output logic                     out_valid,
  output logic [CLASS_W-1:0]       out_class,
  input  logic                     out_ready,
  output logic                     frame_err,
  output logic [ERR_W-1:0]         err_count,
  output logic                     busy
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int CNT_W = 8;
  localparam int BUS_W = N_FEAT * FEAT_W;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_DROP   = 2'd1,
    S_SETTLE = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [FEAT_W-1:0]  r_stage [N_FEAT];
  logic [BUS_W-1:0]   r_feat_bus;
  logic [CLASS_W-1:0] r_out_class;
  logic               r_out_valid;
  logic               r_frame_err;
  logic [ERR_W-1:0]   r_err_count;

  logic w_in_ready;
  logic w_accept;
  logic w_last_idx;
  logic w_commit;
  logic w_err;
  logic w_capture;

  // in_ready depends on registered state only, never on in_valid.
  assign w_in_ready = (r_state == S_LOAD) || (r_state == S_DROP);
  assign w_accept   = in_valid && w_in_ready;
  assign w_last_idx = (r_idx == IDX_W'(N_FEAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (w_last_idx) begin
            w_idx_nxt = '0;
            if (in_last) begin
              w_commit    = 1'b1;
              w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
              w_state_nxt = S_SETTLE;
            end else begin
              // Too many beats: flag once, then swallow the rest of the frame.
              w_err       = 1'b1;
              w_state_nxt = S_DROP;
            end
          end else if (in_last) begin
            w_err     = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_DROP: begin
        if (w_accept && in_last) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_OUT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_FEAT; k++) begin
        r_stage[k] <= '0;
      end
      r_feat_bus  <= '0;
      r_out_class <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_accept && (r_state == S_LOAD)) begin
        r_stage[r_idx] <= in_data;
      end
      // The final beat bypasses the staging bank so the bus updates on its own edge.
      if (w_commit) begin
        for (int k = 0; k < N_FEAT - 1; k++) begin
          r_feat_bus[k*FEAT_W +: FEAT_W] <= r_stage[k];
        end
        r_feat_bus[(N_FEAT-1)*FEAT_W +: FEAT_W] <= in_data;
      end
      if (w_capture) begin
        r_out_class <= tree_class;
        r_out_valid <= 1'b1;
      end else if ((r_state == S_OUT) && out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_frame_err <= w_err;
      if (w_err && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign feat_bus  = r_feat_bus;
  assign out_valid = r_out_valid;
  assign out_class = r_out_class;
  assign frame_err = r_frame_err;
  assign err_count = r_err_count;
  assign busy      = (r_state == S_SETTLE) || (r_state == S_OUT);

endmodule

// File: tb/tb_dtree_frame_loader.sv
// Purpose : randomized self-checking bench for dtree_frame_loader against a frame-level model.
// Latency : checks commit edge, settle interval and result handshake cycle by cycle.
// Backpr. : exercises out_ready stalls and beats offered while the loader is busy.
module tb_dtree_frame_loader;

  localparam int N_FEAT = 9;
  localparam int FEAT_W = 8;
  localparam int CLASS_W = 2;
  localparam int SETTLE = 4;
  localparam int ERR_W = 8;
  localparam int ERR_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [71:0] feat_bus;
  logic [1:0]  tree_class;
  logic        out_valid;
  logic [1:0]  out_class;
  logic        out_ready = 1'b0;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  dtree_frame_loader #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
    .SETTLE_CYCLES(SETTLE), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .feat_bus(feat_bus), .tree_class(tree_class),
    .out_valid(out_valid), .out_class(out_class), .out_ready(out_ready),
    .frame_err(frame_err), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the printed tree: (sum of features + 2) mod 4.
  logic [11:0] tree_sum;
  always_comb begin
    tree_sum = 12'd2;
    for (int k = 0; k < N_FEAT; k++) tree_sum = tree_sum + 12'(feat_bus[k*8 +: 8]);
    tree_class = tree_sum[1:0];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference state.
  logic [71:0] m_feat = '0;
  int          m_err = 0;
  logic [7:0]  fb [16];

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat; returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [7:0] d, input logic l, input bit bub);
    bit ok;
    if (bub) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_last = l;
    ok = 1'b0;
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 72'(0), 72'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic good_frame(input bit fixed, input bit bub, input int hold);
    logic [71:0] ef;
    int s;
    s = 2;
    for (int k = 0; k < N_FEAT; k++) begin
      fb[k] = fixed ? 8'(8'h10 + k) : 8'($urandom);
      ef[k*8 +: 8] = fb[k];
      s += int'(fb[k]);
    end
    out_ready = (hold == 0);
    for (int k = 0; k < N_FEAT; k++) send_beat(fb[k], k == N_FEAT - 1, bub);
    m_feat = ef;
    chk("commit_bus", feat_bus, m_feat);
    chk("commit_err", 72'(frame_err), 72'(0));
    chk("commit_busy", 72'(busy), 72'(1));
    for (int c = 1; c < SETTLE; c++) begin
      @(posedge clk); #1;
      chk("settle_vld", 72'(out_valid), 72'(0));
      chk("settle_rdy", 72'(in_ready), 72'(0));
    end
    @(posedge clk); #1;
    chk("cap_vld", 72'(out_valid), 72'(1));
    chk("cap_class", 72'(out_class), 72'(s % 4));
    if (hold > 0) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("bp_vld", 72'(out_valid), 72'(1));
        chk("bp_class", 72'(out_class), 72'(s % 4));
        chk("bp_rdy", 72'(in_ready), 72'(0));
        chk("bp_bus", feat_bus, m_feat);
      end
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("done_vld", 72'(out_valid), 72'(0));
    chk("done_rdy", 72'(in_ready), 72'(1));
    chk("done_busy", 72'(busy), 72'(0));
    out_ready = 1'b0;
  endtask

  task automatic short_frame(input int n, input bit bub);
    for (int k = 0; k < n; k++) send_beat(8'($urandom), k == n - 1, bub);
    if (m_err < ERR_MAX) m_err++;
    chk("short_err", 72'(frame_err), 72'(1));
    chk("short_cnt", 72'(err_count), 72'(m_err));
    chk("short_bus", feat_bus, m_feat);
    chk("short_rdy", 72'(in_ready), 72'(1));
    @(posedge clk); #1;
    chk("short_pulse", 72'(frame_err), 72'(0));
  endtask

  task automatic long_frame(input int n, input bit bub);
    for (int k = 0; k < n; k++) begin
      send_beat(8'($urandom), k == n - 1, bub);
      if (k == N_FEAT - 1) begin
        if (m_err < ERR_MAX) m_err++;
        chk("long_err", 72'(frame_err), 72'(1));
        chk("long_cnt", 72'(err_count), 72'(m_err));
      end else if (k > N_FEAT - 1) begin
        chk("drop_err", 72'(frame_err), 72'(0));
        chk("drop_rdy", 72'(in_ready), 72'(1));
      end
    end
    chk("long_bus", feat_bus, m_feat);
    chk("long_cnt_end", 72'(err_count), 72'(m_err));
  endtask

  initial begin
    #2;
    chk("rst_bus", feat_bus, 72'(0));
    chk("rst_vld", 72'(out_valid), 72'(0));
    chk("rst_err", 72'(frame_err), 72'(0));
    chk("rst_cnt", 72'(err_count), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_rdy", 72'(in_ready), 72'(1));

    // Directed cases.
    good_frame(1'b1, 1'b0, 0);
    good_frame(1'b1, 1'b0, 10);
    short_frame(5, 1'b0);
    good_frame(1'b0, 1'b1, 0);
    long_frame(12, 1'b0);
    good_frame(1'b0, 1'b0, 0);

    // Randomized mix of frame kinds, bubbles and result stalls.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: short_frame($urandom_range(1, N_FEAT - 1), 1'(($urandom) & 1));
        1: long_frame($urandom_range(N_FEAT + 1, 14), 1'(($urandom) & 1));
        default: good_frame(1'b0, 1'(($urandom) & 1), $urandom_range(0, 3));
      endcase
    end

    // Reset two cycles after a commit, mid-SETTLE.
    for (int k = 0; k < N_FEAT; k++) send_beat(8'($urandom), k == N_FEAT - 1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    m_feat = '0; m_err = 0;
    chk("mid_rst_bus", feat_bus, m_feat);
    chk("mid_rst_vld", 72'(out_valid), 72'(0));
    chk("mid_rst_busy", 72'(busy), 72'(0));
    chk("mid_rst_cnt", 72'(err_count), 72'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("post_rst_vld", 72'(out_valid), 72'(0));
      chk("post_rst_rdy", 72'(in_ready), 72'(1));
    end

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) short_frame(1, 1'b0);
    chk("sat_cnt", 72'(err_count), 72'(ERR_MAX));
    good_frame(1'b0, 1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dtree_frame_loader.md
# dtree_frame_loader

Upstream stage of the printed decision-tree classifier. Receives one 8-bit feature per beat over a valid/ready byte stream and assembles nine features into a stable parallel bus that drives the combinational tree. It waits a programmable settle interval, since printed logic is slow, then captures the tree's class output. The class is returned on a valid/ready result channel, with frame-error detection and counting.

## Interface
Parameters:
- N_FEAT, 9, features per frame (tree inputs X0..X8)
- FEAT_W, 8, feature width in bits
- CLASS_W, 2, tree class output width
- SETTLE_CYCLES, 4, cycles between the feature-bus update and the class capture; legal range 1..255
- ERR_W, 8, error counter width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- clk, input, 1, rising-edge clock
- rst_n, input, 1, asynchronous active-low reset
- in_valid, input, 1, input byte valid
- in_data, input, FEAT_W, feature value; beat k of a frame is feature Xk
- in_last, input, 1, marks the final beat of a frame
- in_ready, output, 1, loader accepts a beat this cycle
- feat_bus, output, N_FEAT*FEAT_W, committed features; X0 in bits [7:0], X8 in bits [71:64]
- tree_class, input, CLASS_W, combinational tree result driven from feat_bus
- out_valid, output, 1, class result valid
- out_class, output, CLASS_W, captured class
- out_ready, input, 1, downstream accepts result
- frame_err, output, 1, one-cycle pulse on a malformed frame
- err_count, output, ERR_W, saturating count of malformed frames
- busy, output, 1, high in SETTLE or OUT

## Operation
- Beat accepted when in_valid && in_ready. Staging bank stage[0..N_FEAT-1] plus beat index idx (0..N_FEAT-1).
- States:
  - LOAD: in_ready=1. On accept, write stage[idx]=in_data.
    - idx==N_FEAT-1 && in_last: commit the whole staging bank (with this beat) to feat_bus, load settle counter with SETTLE_CYCLES-1, go to SETTLE, idx=0.
    - idx<N_FEAT-1 && in_last (short frame): pulse frame_err, increment err_count, idx=0, stay in LOAD. feat_bus is unchanged.
    - idx==N_FEAT-1 && !in_last (long frame): pulse frame_err, increment err_count, go to DROP, idx=0.
    - Otherwise idx++.
  - DROP: in_ready=1. Discard beats until an accepted beat has in_last=1, then go to LOAD. No further error is flagged for that frame.
  - SETTLE: in_ready=0. Decrement the counter; at counter==0, latch out_class=tree_class, set out_valid=1, go to OUT.
  - OUT: in_ready=0, out_valid=1, out_class held. On out_ready, clear out_valid and go to LOAD.
- feat_bus changes only on a good-frame commit, so the tree input is stable through SETTLE and OUT.
- err_count saturates at 2^ERR_W-1; frame_err still pulses at saturation.
- No overlap: the next frame is not accepted until the result handshake completes.

## Timing
- Reset (async assert, sync-release behaviour per the team's reset macro):
  - state=LOAD, idx=0.
  - feat_bus, stage, out_class, err_count all 0.
  - out_valid=0, frame_err=0, busy=0.
  - in_ready=1 from the first clock after reset release.
- in_ready, busy: decoded from registered state, with no combinational path from in_valid.
- feat_bus updates on the edge that accepts the last beat (edge T).
- tree_class is sampled at edge T+SETTLE_CYCLES; out_valid is high from the same edge.
- Minimum frame-to-result latency: N_FEAT accept edges + SETTLE_CYCLES.
- out_valid stays high for at least one cycle and holds until out_ready. With out_ready already high, OUT lasts exactly one cycle; in_ready returns the next cycle.
- frame_err is registered, high for the cycle after the offending accept edge.
- rst_n asserted mid-frame or mid-SETTLE aborts immediately; the partial frame is lost and out_valid does not assert.

## Test plan
- Good frame: bytes 0x10..0x18 on consecutive cycles, in_last on the 9th, tree_class=2, SETTLE_CYCLES=4, out_ready=1.
  - Expect feat_bus=0x181716151413121110 after the 9th accept.
  - Expect out_valid with out_class=2 exactly 4 edges later.
  - Expect in_ready=0 through SETTLE/OUT, back to 1 after the handshake.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - Expect out_class held, in_ready=0, and beats offered meanwhile not accepted.
  - out_ready=1 gives a single transfer.
- Short frame: 5 beats with in_last on the 5th.
  - Expect a 1-cycle frame_err, err_count=1, feat_bus unchanged.
  - A following good frame classifies normally.
- Long frame: 12 beats with in_last on the 12th.
  - Expect frame_err on the 9th accept, beats 10..12 dropped, err_count=1.
  - The next 9-beat frame commits correctly.
- Stall/bubbles: in_valid toggled randomly during a frame. Expect the same feat_bus as back-to-back delivery.
- Reset mid-SETTLE: assert rst_n low 2 cycles after the commit.
  - Expect out_valid never high, feat_bus=0, in_ready=1 after release.
- Saturation: 260 short frames with ERR_W=8. Expect err_count stuck at 255 and frame_err still pulsing.
